// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_pkg: state, opcode and mux-select encodings for the multicycle RV32I control path
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_imm_src_decoder.sv
// imm_src_decoder: opcode to immediate-format select, shared with the datapath
module imm_src_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb
        imm_src = (op == OP_SW)  ? IMM_S :
                  (op == OP_BEQ) ? IMM_B :
                  (op == OP_JAL) ? IMM_J : IMM_I;

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: per-instruction sequencer for the multicycle RV32I datapath
module multicycle_control_fsm
    import multicycle_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               mem_req,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [1:0]         alu_op,
    output logic               reg_write,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    state_t     state, state_next;
    logic       ready;
    logic [1:0] imm_dec;

    assign ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign imm_src   = rst_n ? imm_dec : 2'b00;
    assign dbg_state = STATE_W'(state);

    imm_src_decoder u_imm (.op(op), .imm_src(imm_dec));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FETCH;
        else        state <= state_next;

    // Everything is gated by rst_n so a reset mid-instruction drops all enables at once
    always_comb begin
        state_next = FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        if (rst_n)
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    ir_write   = ready;
                    pc_write   = ready;
                    state_next = ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (op)
                        OP_LW, OP_SW: state_next = MEMADR;
                        OP_R:         state_next = EXECR;
                        OP_I:         state_next = EXECI;
                        OP_JAL:       state_next = JAL;
                        OP_BEQ:       state_next = BEQ;
                        default:      illegal_op = 1'b1;
                    endcase
                end
                MEMADR: begin
                    alu_src_a  = SRCA_RD1;
                    alu_src_b  = SRCB_IMM;
                    state_next = (op == OP_LW) ? MEMREAD : (op == OP_SW) ? MEMWRITE : FETCH;
                end
                MEMREAD: begin
                    mem_req    = 1'b1;
                    adr_src    = 1'b1;
                    state_next = ready ? MEMWB : MEMREAD;
                end
                MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    mem_req    = 1'b1;
                    adr_src    = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = ready;
                    state_next = ready ? FETCH : MEMWRITE;
                end
                EXECR: begin
                    alu_src_a  = SRCA_RD1;
                    alu_op     = ALUOP_FUNCT;
                    state_next = ALUWB;
                end
                EXECI: begin
                    alu_src_a  = SRCA_RD1;
                    alu_src_b  = SRCB_IMM;
                    alu_op     = ALUOP_FUNCT;
                    state_next = ALUWB;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                JAL: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    pc_write   = 1'b1;
                    state_next = ALUWB;
                end
                BEQ: begin
                    alu_src_a  = SRCA_RD1;
                    alu_op     = ALUOP_SUB;
                    pc_write   = zero;
                    instr_done = 1'b1;
                end
                default: state_next = FETCH;
            endcase
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main sequencing controller for the multicycle RV32I datapath. It replaces the single-cycle combinational control path.
- Each instruction is walked through fetch, decode, execute, memory and writeback states. The FSM drives the PC, IR, register-file and memory enables and the datapath mux selects.
- It emits the 2-bit ALUOp consumed by the existing ALU decoder.
- A ready handshake stalls the FSM on every memory access to the shared instruction/data memory.

Parameters:
- MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready is treated as constant 1 (single-cycle memory).
- STATE_W, 4, width of the state register and of the dbg_state port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode field from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- mem_req  out  1  memory access in progress.
- ir_write  out  1  IR and OldPC load enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU input A select: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU input B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- imm_src  out  2  immediate format: I = 00, S = 01, B = 10, J = 11; decoded combinationally from op.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- reg_write  out  1  register-file write enable.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- dbg_state  out  STATE_W  current state.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst_n is asynchronous, active-low.
- rst_n low:
  - state forced to FETCH immediately.
  - All enables (pc_write, mem_write, mem_req, ir_write, reg_write, instr_done, illegal_op) held 0.
  - All selects held 0.
  - The first fetch starts on the first rising edge after rst_n rises.
  - Reset mid-instruction abandons it; no partial writes.
- Outputs are combinational from state plus op, zero and mem_ready. State is registered.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, jal 1101111, beq 1100011.

States and per-state outputs (unlisted signals are 0):
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - When mem_ready=1: ir_write=1 and pc_write=1 (PC <- PC+4), then go to DECODE. Otherwise stay in FETCH with ir_write=0 and pc_write=0.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00, computing the branch/jump target OldPC+imm.
  - Next state by op: lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; jal -> JAL; beq -> BEQ.
  - Any other opcode: illegal_op=1, next state FETCH, no instr_done.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. When mem_ready=1, go to MEMWB; otherwise hold.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
- MEMWRITE:
  - mem_req=1, adr_src=1, mem_write=1.
  - mem_write stays high throughout the stall; the memory samples it on the ready cycle.
  - When mem_ready=1: instr_done=1, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, then FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC <- ALUOut target).
  - Then ALUWB, which writes rd = OldPC+4. instr_done fires in ALUWB.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero. instr_done=1, then FETCH.
- Undefined state encodings recover to FETCH on the next edge.

Boundary conditions:
- mem_ready only affects FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.
- With MEM_HANDSHAKE=0, lw takes 5 cycles, sw 4, R/I 4, jal 4, beq 3.
- op is sampled only in DECODE and MEMADR. The IR is stable there because ir_write=0.
- illegal_op and instr_done are never both high in the same cycle.

Decomposition:
- Package multicycle_pkg holds:
  - state encodings (FETCH = 0 through BEQ = 10);
  - opcode constants;
  - result_src, alu_src_a, alu_src_b and alu_op encodings.
- Sub-module imm_src_decoder: combinational op -> imm_src, reused by the datapath.

Test Plan:
- Reset with mem_ready held at 1; release rst_n mid-cycle; op=0110011 -> FETCH(ir_write=1, pc_write=1), DECODE, EXECR(alu_op=10), ALUWB(reg_write=1, instr_done=1), back to FETCH; 4 cycles total.
- lw (op=0000011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD -> ir_write only on the ready cycle; MEMWB result_src=01, reg_write=1; 10 cycles total.
- sw (op=0100011) with mem_ready=1 -> MEMWRITE asserts mem_write=1, adr_src=1, instr_done=1 for exactly 1 cycle; reg_write is never 1.
- beq (op=1100011) with zero=1 and then zero=0 -> pc_write=1 in BEQ for the first case, 0 for the second; each instruction takes 3 cycles.
- jal (op=1101111) -> pc_write=1 in JAL, then ALUWB with reg_write=1, result_src=00; imm_src=11 throughout.
- op=1111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH, no instr_done. Separately, rst_n pulled low during MEMREAD -> all enables 0 immediately and dbg_state=FETCH.
